// File: rtl/push_pop_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// push_pop_sequencer_pkg
// Shared definitions for the PUSH/POP micro-op sequencer: the micro-op kind
// seen by the rest of the decode stage, the sequencer's internal states,
// the architectural addresses of SP/LR/PC and the Thumb opcode prefixes.
// ----------------------------------------------------------------------------
package push_pop_sequencer_pkg;

   typedef enum logic [1:0] {
      UOP_NONE   = 2'd0,
      UOP_STORE  = 2'd1,
      UOP_LOAD   = 2'd2,
      UOP_SP_ADJ = 2'd3
   } uop_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REGS    = 2'd1,
      ST_SP_ADJ  = 2'd2,
      ST_PC_LOAD = 2'd3
   } seq_state_t;

   localparam logic [3:0] SP_ADDR = 4'd13;
   localparam logic [3:0] LR_ADDR = 4'd14;
   localparam logic [3:0] PC_ADDR = 4'd15;

   localparam logic [6:0] PUSH_OPCODE = 7'b1011010;
   localparam logic [6:0] POP_OPCODE  = 7'b1011110;

endpackage

// File: rtl/push_pop_sequencer_encoder.sv
// ----------------------------------------------------------------------------
// lowest_set_bit_encoder
// Finds the lowest set bit of a 9-bit register-list mask.
// Ports:
//   mask_i  - remaining register list (bit 0 = R0)
//   index_o - position of the lowest set bit (0..8), 0 when empty
//   none_o  - high when the mask is empty
// ----------------------------------------------------------------------------
module lowest_set_bit_encoder (
   input  logic [8:0] mask_i,
   output logic [3:0] index_o,
   output logic       none_o
);

   // Scan from the top down so the last hit, the lowest set bit, wins.
   always_comb begin
      index_o = 4'd0;
      none_o  = 1'b1;
      for (int i = 8; i >= 0; i--) begin
         if (mask_i[i]) begin
            index_o = 4'(i);
            none_o  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/push_pop_sequencer.sv
// ----------------------------------------------------------------------------
// push_pop_sequencer
// Expands a Thumb PUSH/POP into one memory micro-op per listed register plus
// an SP-adjust micro-op (and a final PC load for POP {.., PC}). Fetch is
// stalled while the sequence runs.
// Ports:
//   clk_i, reset_i   - clock (rising edge), async active-high reset
//   is_valid_i       - decode-stage instruction valid
//   instruction_i    - Thumb instruction in decode
//   hold_i           - hazard stall, freezes the current micro-op
//   flush_i          - pipeline flush, aborts the sequence
//   uop_valid_o      - a micro-op is presented this cycle
//   uop_kind_o       - NONE / STORE / LOAD / SP_ADJ
//   uop_reg_addr_o   - register moved, or SP for SP_ADJ
//   uop_offset_o     - byte offset from current SP, or SP delta
//   uop_last_o       - final micro-op of the instruction
//   uop_branch_o     - micro-op loads PC
//   stall_fetch_o    - hold fetch/PC and the decode input
//   busy_o           - sequencer is past its first micro-op
// ----------------------------------------------------------------------------
module push_pop_sequencer
   import push_pop_sequencer_pkg::*;
#(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  is_valid_i,
   input  logic [15:0]           instruction_i,
   input  logic                  hold_i,
   input  logic                  flush_i,
   output logic                  uop_valid_o,
   output uop_kind_t             uop_kind_o,
   output logic [ADDR_WIDTH-1:0] uop_reg_addr_o,
   output logic [WORD-1:0]       uop_offset_o,
   output logic                  uop_last_o,
   output logic                  uop_branch_o,
   output logic                  stall_fetch_o,
   output logic                  busy_o
);

   seq_state_t state_q, state_d, emitState;
   logic [8:0] mask_q, mask_d;
   logic [3:0] k_q, k_d;
   logic [3:0] n_q, n_d;
   logic       pop_q, pop_d;

   logic       isPush, isPop, accept;
   logic [3:0] instrCount;
   logic [8:0] ctxMask, regMask, lsbBit;
   logic [3:0] ctxK, ctxN, lsbIdx;
   logic       ctxPop, hasPc, lsbNone;
   logic [WORD-1:0] kWord, nWord;

   // Sequencer context registers. Reset returns to IDLE with nothing pending.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         k_q     <= '0;
         n_q     <= '0;
         pop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         k_q     <= k_d;
         n_q     <= n_d;
         pop_q   <= pop_d;
      end
   end

   // Decode the instruction in decode and count its register list. Only
   // meaningful while IDLE; afterwards the latched copies take over.
   always_comb begin
      isPush     = (instruction_i[15:9] == PUSH_OPCODE);
      isPop      = (instruction_i[15:9] == POP_OPCODE);
      accept     = is_valid_i & (isPush | isPop);
      instrCount = '0;
      for (int i = 0; i < 9; i++) begin
         instrCount = instrCount + {3'b000, instruction_i[i]};
      end
   end

   // Pick the live context: the raw instruction while IDLE so the first
   // micro-op appears in the accept cycle, the registered copy afterwards.
   // For POP, bit 8 is the PC and stays out of the register walk; it is
   // kept in the mask so SP_ADJ still knows a PC load follows.
   always_comb begin
      if (state_q == ST_IDLE) begin
         ctxMask = instruction_i[8:0];
         ctxK    = '0;
         ctxN    = instrCount;
         ctxPop  = isPop;
      end else begin
         ctxMask = mask_q;
         ctxK    = k_q;
         ctxN    = n_q;
         ctxPop  = pop_q;
      end
      regMask = ctxPop ? {1'b0, ctxMask[7:0]} : ctxMask;
      hasPc   = ctxPop & ctxMask[8];
   end

   lowest_set_bit_encoder uEncoder (
      .mask_i  (regMask),
      .index_o (lsbIdx),
      .none_o  (lsbNone)
   );

   // Micro-op generation and next state. emitState names the step whose
   // micro-op is on the outputs this cycle; while IDLE an accepted
   // instruction jumps straight to its first step (REGS, or SP_ADJ for an
   // empty register walk). The step then decides where the sequence goes.
   // hold_i freezes everything, flush_i then overrides hold and aborts, and
   // reset forces the outputs quiet.
   always_comb begin
      emitState = state_q;
      if (state_q == ST_IDLE && accept) begin
         emitState = lsbNone ? ST_SP_ADJ : ST_REGS;
      end

      uop_valid_o    = 1'b0;
      uop_kind_o     = UOP_NONE;
      uop_reg_addr_o = '0;
      uop_offset_o   = '0;
      uop_last_o     = 1'b0;
      uop_branch_o   = 1'b0;

      state_d = state_q;
      mask_d  = mask_q;
      k_d     = k_q;
      n_d     = n_q;
      pop_d   = pop_q;

      lsbBit = 9'b1 << lsbIdx;
      kWord  = WORD'({ctxK, 2'b00});
      nWord  = WORD'({ctxN, 2'b00});

      if (emitState != ST_IDLE) begin
         n_d   = ctxN;
         pop_d = ctxPop;
      end

      case (emitState)
         ST_REGS: begin
            uop_valid_o    = 1'b1;
            uop_kind_o     = ctxPop ? UOP_LOAD : UOP_STORE;
            uop_reg_addr_o = (lsbIdx == 4'd8) ? ADDR_WIDTH'(LR_ADDR) : ADDR_WIDTH'(lsbIdx);
            uop_offset_o   = ctxPop ? kWord : (kWord - nWord);
            mask_d         = ctxMask & ~lsbBit;
            k_d            = ctxK + 4'd1;
            state_d        = ((regMask & ~lsbBit) != 9'd0) ? ST_REGS : ST_SP_ADJ;
         end
         ST_SP_ADJ: begin
            uop_valid_o    = 1'b1;
            uop_kind_o     = UOP_SP_ADJ;
            uop_reg_addr_o = ADDR_WIDTH'(SP_ADDR);
            uop_offset_o   = ctxPop ? nWord : (WORD'(0) - nWord);
            uop_last_o     = ~hasPc;
            mask_d         = hasPc ? ctxMask : 9'd0;
            k_d            = hasPc ? ctxK : 4'd0;
            state_d        = hasPc ? ST_PC_LOAD : ST_IDLE;
         end
         ST_PC_LOAD: begin
            uop_valid_o    = 1'b1;
            uop_kind_o     = UOP_LOAD;
            uop_reg_addr_o = ADDR_WIDTH'(PC_ADDR);
            uop_offset_o   = nWord - WORD'(4);
            uop_last_o     = 1'b1;
            uop_branch_o   = 1'b1;
            mask_d         = '0;
            k_d            = '0;
            state_d        = ST_IDLE;
         end
         default: begin
         end
      endcase

      if (hold_i) begin
         state_d = state_q;
         mask_d  = mask_q;
         k_d     = k_q;
         n_d     = n_q;
         pop_d   = pop_q;
      end

      if (flush_i) begin
         state_d = ST_IDLE;
         mask_d  = '0;
         k_d     = '0;
      end

      if (reset_i) begin
         uop_valid_o    = 1'b0;
         uop_kind_o     = UOP_NONE;
         uop_reg_addr_o = '0;
         uop_offset_o   = '0;
         uop_last_o     = 1'b0;
         uop_branch_o   = 1'b0;
      end
   end

   // Fetch only waits while more micro-ops of this instruction follow.
   assign stall_fetch_o = uop_valid_o & ~uop_last_o;
   assign busy_o        = ~reset_i & (state_q != ST_IDLE);

endmodule

// File: tb/tb_push_pop_sequencer.sv
// ----------------------------------------------------------------------------
// tb_push_pop_sequencer
// Drives directed and random PUSH/POP instructions into push_pop_sequencer
// and compares every presented micro-op against a list-based reference
// model built from the instruction encoding.
// ----------------------------------------------------------------------------
module tb_push_pop_sequencer;
   import push_pop_sequencer_pkg::*;

   localparam int WORD       = 32;
   localparam int ADDR_WIDTH = 4;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic                  is_valid_i;
   logic [15:0]           instruction_i;
   logic                  hold_i;
   logic                  flush_i;
   logic                  uop_valid_o;
   uop_kind_t             uop_kind_o;
   logic [ADDR_WIDTH-1:0] uop_reg_addr_o;
   logic [WORD-1:0]       uop_offset_o;
   logic                  uop_last_o;
   logic                  uop_branch_o;
   logic                  stall_fetch_o;
   logic                  busy_o;

   typedef struct {
      uop_kind_t   kind;
      logic [3:0]  addr;
      logic [31:0] offset;
      logic        last;
      logic        branch;
   } uop_t;

   uop_t expQ[$];
   int   assertCount = 0;
   int   failCount   = 0;
   int   cycles;

   push_pop_sequencer #(.WORD(WORD), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .is_valid_i     (is_valid_i),
      .instruction_i  (instruction_i),
      .hold_i         (hold_i),
      .flush_i        (flush_i),
      .uop_valid_o    (uop_valid_o),
      .uop_kind_o     (uop_kind_o),
      .uop_reg_addr_o (uop_reg_addr_o),
      .uop_offset_o   (uop_offset_o),
      .uop_last_o     (uop_last_o),
      .uop_branch_o   (uop_branch_o),
      .stall_fetch_o  (stall_fetch_o),
      .busy_o         (busy_o)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk_i = ~clk_i;

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: the full micro-op list an instruction should produce,
   // written straight from the register-list rules.
   task automatic buildModel(input logic [15:0] instr);
      int         n;
      bit         pop, pc;
      logic [3:0] regs[$];
      uop_t       u;
      expQ.delete();
      pop = (instr[15:9] == 7'b1011110);
      pc  = pop && instr[8];
      n   = 0;
      for (int i = 0; i < 9; i++) n += int'(instr[i]);
      for (int i = 0; i < 8; i++) if (instr[i]) regs.push_back(4'(i));
      if (!pop && instr[8]) regs.push_back(4'd14);
      foreach (regs[j]) begin
         u.kind   = pop ? UOP_LOAD : UOP_STORE;
         u.addr   = regs[j];
         u.offset = pop ? 32'(4 * j) : 32'(4 * j - 4 * n);
         u.last   = 1'b0;
         u.branch = 1'b0;
         expQ.push_back(u);
      end
      u.kind   = UOP_SP_ADJ;
      u.addr   = 4'd13;
      u.offset = pop ? 32'(4 * n) : 32'(-4 * n);
      u.last   = !pc;
      u.branch = 1'b0;
      expQ.push_back(u);
      if (pc) begin
         u.kind   = UOP_LOAD;
         u.addr   = 4'd15;
         u.offset = 32'(4 * (n - 1));
         u.last   = 1'b1;
         u.branch = 1'b1;
         expQ.push_back(u);
      end
   endtask

   // Present one instruction, walk its micro-ops with the given hold
   // pattern (or random holds) and an optional flush, then check that the
   // sequencer goes quiet once decode moves on.
   task automatic applyStimulus(input logic [15:0] instr, input logic [31:0] holdPat,
                                input bit randHold, input int flushAt, output int cycleCount);
      bit isPp, h, f;
      int idx;
      isPp = (instr[15:9] == 7'b1011010) || (instr[15:9] == 7'b1011110);
      idx  = 0;
      cycleCount = 0;
      if (!isPp) begin
         @(negedge clk_i);
         instruction_i = instr; is_valid_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
         #1;
         checkOutput("otherValid", 32'(uop_valid_o), 32'd0);
         checkOutput("otherBusy", 32'(busy_o), 32'd0);
         checkOutput("otherStall", 32'(stall_fetch_o), 32'd0);
         cycleCount = 1;
      end else begin
         buildModel(instr);
         while (idx < expQ.size()) begin
            @(negedge clk_i);
            h = randHold ? ($urandom_range(0, 3) == 0) : holdPat[cycleCount % 32];
            f = (flushAt > 0) && (idx == flushAt);
            instruction_i = instr; is_valid_i = 1'b1; hold_i = h; flush_i = f;
            #1;
            checkOutput("valid", 32'(uop_valid_o), 32'd1);
            checkOutput("kind", 32'(uop_kind_o), 32'(expQ[idx].kind));
            checkOutput("addr", 32'(uop_reg_addr_o), 32'(expQ[idx].addr));
            checkOutput("offset", uop_offset_o, expQ[idx].offset);
            checkOutput("last", 32'(uop_last_o), 32'(expQ[idx].last));
            checkOutput("branch", 32'(uop_branch_o), 32'(expQ[idx].branch));
            checkOutput("stall", 32'(stall_fetch_o), 32'(!expQ[idx].last));
            checkOutput("busy", 32'(busy_o), 32'(idx > 0));
            cycleCount++;
            @(posedge clk_i);
            if (f) break;
            if (!h) idx++;
         end
      end
      @(negedge clk_i);
      is_valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0; instruction_i = 16'($urandom);
      #1;
      checkOutput("afterValid", 32'(uop_valid_o), 32'd0);
      checkOutput("afterBusy", 32'(busy_o), 32'd0);
      checkOutput("afterStall", 32'(stall_fetch_o), 32'd0);
   endtask

   // Directed scenarios first, then a randomized mix.
   initial begin
      logic [15:0] instr;
      int          flushAt;

      reset_i = 1'b1; is_valid_i = 1'b1; instruction_i = 16'hB505; hold_i = 1'b0; flush_i = 1'b0;
      #2;
      checkOutput("resetValid", 32'(uop_valid_o), 32'd0);
      checkOutput("resetKind", 32'(uop_kind_o), 32'(UOP_NONE));
      checkOutput("resetStall", 32'(stall_fetch_o), 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0; is_valid_i = 1'b0;

      applyStimulus(16'hB505, 32'd0, 1'b0, -1, cycles);
      checkOutput("pushCycles", 32'(cycles), 32'd4);
      applyStimulus(16'hBD02, 32'd0, 1'b0, -1, cycles);
      checkOutput("popPcCycles", 32'(cycles), 32'd3);
      applyStimulus(16'hB403, 32'b110, 1'b0, -1, cycles);
      checkOutput("holdCycles", 32'(cycles), 32'd5);
      applyStimulus(16'hB4FF, 32'd0, 1'b0, 2, cycles);
      checkOutput("flushCycles", 32'(cycles), 32'd3);
      applyStimulus(16'hB400, 32'd0, 1'b0, -1, cycles);
      checkOutput("emptyCycles", 32'(cycles), 32'd1);
      applyStimulus(16'h1C08, 32'd0, 1'b0, -1, cycles);

      @(negedge clk_i);
      instruction_i = 16'hBD0F; is_valid_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
      @(posedge clk_i);
      @(posedge clk_i);
      #2;
      reset_i = 1'b1;
      #1;
      checkOutput("midResetValid", 32'(uop_valid_o), 32'd0);
      checkOutput("midResetKind", 32'(uop_kind_o), 32'(UOP_NONE));
      checkOutput("midResetAddr", 32'(uop_reg_addr_o), 32'd0);
      checkOutput("midResetOffset", uop_offset_o, 32'd0);
      checkOutput("midResetLast", 32'(uop_last_o), 32'd0);
      checkOutput("midResetBranch", 32'(uop_branch_o), 32'd0);
      checkOutput("midResetStall", 32'(stall_fetch_o), 32'd0);
      checkOutput("midResetBusy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      reset_i = 1'b0; is_valid_i = 1'b0;
      applyStimulus(16'hBC01, 32'd0, 1'b0, -1, cycles);
      checkOutput("postResetCycles", 32'(cycles), 32'd2);

      for (int t = 0; t < 60; t++) begin
         case ($urandom_range(0, 4))
            0:       instr = 16'($urandom);
            1, 2:    instr = {7'b1011010, 9'($urandom)};
            default: instr = {7'b1011110, 9'($urandom)};
         endcase
         flushAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
         applyStimulus(instr, 32'd0, 1'b1, flushAt, cycles);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
